// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Shares one lot occupancy counter between GATES gate FSMs.
//               Entry/exit pulses are latched as pending requests and one is
//               served per cycle in round-robin order. Occupancy is held within
//               [0, CAPACITY]. The module drives full/empty status, entry
//               locks, a reject pulse and sticky lost-event/underflow flags.
//               Optional feature macro: PARKING_ARB_STATS_EN adds the
//               entries_total / exits_total 16-bit accepted-event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
    parameter int GATES    = 4,
    parameter int BITS     = 8,
    parameter int CAPACITY = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [GATES-1:0] enter_evt,
    input  logic [GATES-1:0] exit_evt,
    output logic [BITS-1:0]  occupancy,
    output logic             full,
    output logic             empty,
    output logic [GATES-1:0] gate_lock,
    output logic             reject,
    output logic             lost_evt,
    output logic             underflow
`ifdef PARKING_ARB_STATS_EN
    ,
    output logic [15:0]      entries_total,
    output logic [15:0]      exits_total
`endif
);

    // Requesters: exits occupy indices [0, GATES), entries [GATES, 2*GATES)
    localparam int              C_NREQ = 2 * GATES;
    localparam int              C_PW   = $clog2(C_NREQ);
    localparam logic [BITS-1:0] C_CAP  = BITS'(CAPACITY);
    localparam logic [BITS-1:0] C_ONE  = BITS'(1);

    logic [C_NREQ-1:0] pend_q, pend_d;
    logic [C_PW-1:0]   ptr_q, ptr_d;
    logic [BITS-1:0]   occ_q, occ_d;
    logic              full_q, empty_q, reject_q, lost_q, under_q;
    logic              reject_d, under_d;

    logic [C_NREQ-1:0] w_evt;
    logic [C_NREQ-1:0] w_grant_vec;
    logic              w_grant_valid;
    logic [C_PW-1:0]   w_grant_idx;
    logic              w_serve_exit;
    logic              w_serve_enter;
    logic              w_lost;

    assign w_evt = {enter_evt, exit_evt};

    // Round-robin search starting one past the last granted requester
    always_comb begin
        int j;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        j             = 0;
        for (int i = 1; i <= C_NREQ; i++) begin
            j = (int'(ptr_q) + i) % C_NREQ;
            if (!w_grant_valid && pend_q[j]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = C_PW'(j);
            end
        end
        w_grant_vec = w_grant_valid ? (C_NREQ'(1) << w_grant_idx) : '0;
        ptr_d       = w_grant_valid ? w_grant_idx : ptr_q;
    end

    assign w_serve_exit  = w_grant_valid && (w_grant_idx < C_PW'(GATES));
    assign w_serve_enter = w_grant_valid && !w_serve_exit;

    // Capture new pulses; a pulse landing on a granted requester is kept,
    // a pulse landing on a still-pending requester is dropped and flagged
    always_comb begin
        pend_d = (pend_q & ~w_grant_vec) | w_evt;
        w_lost = |(w_evt & pend_q & ~w_grant_vec);
    end

    // Apply the served event to occupancy with saturation at both ends
    always_comb begin
        occ_d    = occ_q;
        under_d  = under_q;
        reject_d = 1'b0;
        if (w_serve_exit) begin
            if (occ_q != '0) begin
                occ_d = occ_q - C_ONE;
            end else begin
                under_d = 1'b1;
            end
        end else if (w_serve_enter) begin
            if (occ_q < C_CAP) begin
                occ_d = occ_q + C_ONE;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    // State register; status flags follow the updated occupancy in lockstep
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= '0;
            ptr_q    <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            reject_q <= 1'b0;
            lost_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            occ_q    <= occ_d;
            full_q   <= (occ_d == C_CAP);
            empty_q  <= (occ_d == '0);
            reject_q <= reject_d;
            lost_q   <= lost_q | w_lost;
            under_q  <= under_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign gate_lock = {GATES{full_q}};
    assign reject    = reject_q;
    assign lost_evt  = lost_q;
    assign underflow = under_q;

`ifdef PARKING_ARB_STATS_EN
    logic [15:0] entries_q;
    logic [15:0] exits_q;
    logic        w_acc_enter;
    logic        w_acc_exit;

    assign w_acc_enter = w_serve_enter && (occ_q < C_CAP);
    assign w_acc_exit  = w_serve_exit && (occ_q != '0);

    // Count accepted events only; both counters wrap naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
            exits_q   <= '0;
        end else begin
            if (w_acc_enter) entries_q <= entries_q + 16'd1;
            if (w_acc_exit)  exits_q   <= exits_q + 16'd1;
        end
    end

    assign entries_total = entries_q;
    assign exits_total   = exits_q;
`endif

endmodule
`default_nettype wire
